// File: rtl/descrambler_pkg.sv
// Shared definitions for the 802.11a x^7+x^4+1 scrambler/descrambler pair:
// FSM encoding, seed length and feedback taps.
package descrambler_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEED = 2'd1,
        DATA = 2'd2
    } descramblerState_t;

    localparam int SEED_BITS = 7;
    localparam int TAP_HIGH  = 6;
    localparam int TAP_LOW   = 3;

    function automatic logic feedbackBit(input logic [SEED_BITS-1:0] lfsrState);
        return lfsrState[TAP_HIGH] ^ lfsrState[TAP_LOW];
    endfunction

endpackage

// File: rtl/descrambler_if.sv
// Bit-serial stream between the Viterbi decoder, the descrambler and the bit sink.
interface descrambler_if;

    logic Descrambler_DataIN;
    logic Descrambler_DataIN_VALID;
    logic Descrambler_DataOUT;
    logic Descrambler_DataOUTVALID;

    modport master (
        output Descrambler_DataIN,
        output Descrambler_DataIN_VALID,
        input  Descrambler_DataOUT,
        input  Descrambler_DataOUTVALID
    );

    modport slave (
        input  Descrambler_DataIN,
        input  Descrambler_DataIN_VALID,
        output Descrambler_DataOUT,
        output Descrambler_DataOUTVALID
    );

endinterface

// File: rtl/descrambler_lfsr.sv
// 7-bit x^7+x^4+1 register: either loads received bits (seed recovery) or
// free-runs on its own feedback (descrambling).
module descrambler_lfsr
    import descrambler_pkg::*;
(
    input  logic                 clock,
    input  logic                 resetN,
    input  logic                 clear,
    input  logic                 loadBit,
    input  logic                 shiftEn,
    input  logic                 dataIn,
    output logic [SEED_BITS-1:0] shiftedIn,
    output logic                 feedback
);

    logic [SEED_BITS-1:0] lfsrReg;

    assign feedback  = feedbackBit(lfsrReg);
    assign shiftedIn = {lfsrReg[SEED_BITS-2:0], dataIn};

    always_ff @(posedge clock) begin
        if (!resetN) begin
            lfsrReg <= '0;
        end else if (clear) begin
            lfsrReg <= '0;
        end else if (loadBit) begin
            lfsrReg <= shiftedIn;
        end else if (shiftEn) begin
            lfsrReg <= {lfsrReg[SEED_BITS-2:0], feedback};
        end
    end

endmodule

// File: rtl/descrambler.sv
// 802.11a receive descrambler: recovers the seed from the first 7 SERVICE bits,
// then descrambles the frame. DESCRAMBLER_SERVICE_CHECK_EN adds a reserved-SERVICE-bit check.
module descrambler
    import descrambler_pkg::*;
#(
    parameter int COUNT_WIDTH = 16,
    parameter int SEED_BITS   = descrambler_pkg::SEED_BITS
) (
    input  logic                   clock,
    input  logic                   Descrambler_Reset,
    input  logic                   Descrambler_Start,
    input  logic [COUNT_WIDTH-1:0] Descrambler_NumBits,
    descrambler_if.slave           stream,
    output logic                   Descrambler_Busy,
    output logic                   Descrambler_FrameDone,
    output logic [SEED_BITS-1:0]   Descrambler_SeedOUT
`ifdef DESCRAMBLER_SERVICE_CHECK_EN
    ,
    output logic                   Descrambler_ServiceError
`endif
);

    descramblerState_t    stateReg, stateNext;
    logic [COUNT_WIDTH-1:0] remainingReg;
    logic [2:0]           seedCountReg;
    logic                 startFrame, accept, lastBit, seedDone;
    logic [SEED_BITS-1:0] shiftedIn;
    logic                 feedback;

    assign startFrame = (stateReg == IDLE) && Descrambler_Start && (Descrambler_NumBits != '0);
    assign accept     = (stateReg != IDLE) && stream.Descrambler_DataIN_VALID;
    assign lastBit    = accept && (remainingReg == COUNT_WIDTH'(1));
    assign seedDone   = accept && (stateReg == SEED) && (seedCountReg == 3'(SEED_BITS - 1));
    assign Descrambler_Busy = (stateReg != IDLE);

    descrambler_lfsr lfsrInst (
        .clock     (clock),
        .resetN    (Descrambler_Reset),
        .clear     (startFrame),
        .loadBit   (accept && (stateReg == SEED)),
        .shiftEn   (accept && (stateReg == DATA)),
        .dataIn    (stream.Descrambler_DataIN),
        .shiftedIn (shiftedIn),
        .feedback  (feedback)
    );

    always_comb begin
        stateNext = stateReg;
        case (stateReg)
            IDLE: if (startFrame) stateNext = SEED;
            SEED: begin
                if (lastBit)       stateNext = IDLE;
                else if (seedDone) stateNext = DATA;
            end
            DATA: if (lastBit) stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!Descrambler_Reset) begin
            stateReg                        <= IDLE;
            remainingReg                    <= '0;
            seedCountReg                    <= '0;
            stream.Descrambler_DataOUT      <= 1'b0;
            stream.Descrambler_DataOUTVALID <= 1'b0;
            Descrambler_FrameDone           <= 1'b0;
            Descrambler_SeedOUT             <= '0;
        end else begin
            stateReg                        <= stateNext;
            stream.Descrambler_DataOUTVALID <= accept;
            Descrambler_FrameDone           <= lastBit;
            // SERVICE init bits descramble to zero by definition
            stream.Descrambler_DataOUT      <= accept && (stateReg == DATA)
                                               && (stream.Descrambler_DataIN ^ feedback);
            if (startFrame) begin
                remainingReg <= Descrambler_NumBits;
                seedCountReg <= '0;
            end else if (accept) begin
                remainingReg <= remainingReg - COUNT_WIDTH'(1);
                if (stateReg == SEED) seedCountReg <= seedCountReg + 3'd1;
            end
            if (seedDone) Descrambler_SeedOUT <= shiftedIn;
        end
    end

`ifdef DESCRAMBLER_SERVICE_CHECK_EN
    logic [4:0] bitPosReg;
    logic       serviceFlagReg;
    logic       serviceBitErr;

    // DATA begins at frame bit 7, so positions 7..15 are the reserved SERVICE bits
    assign serviceBitErr = accept && (stateReg == DATA) && (bitPosReg < 5'd16)
                           && (stream.Descrambler_DataIN ^ feedback);

    always_ff @(posedge clock) begin
        if (!Descrambler_Reset) begin
            bitPosReg                <= '0;
            serviceFlagReg           <= 1'b0;
            Descrambler_ServiceError <= 1'b0;
        end else if (startFrame) begin
            bitPosReg                <= '0;
            serviceFlagReg           <= 1'b0;
            Descrambler_ServiceError <= 1'b0;
        end else if (accept) begin
            if (bitPosReg < 5'd16) bitPosReg <= bitPosReg + 5'd1;
            if (serviceBitErr) serviceFlagReg <= 1'b1;
            if (lastBit) Descrambler_ServiceError <= serviceFlagReg | serviceBitErr;
        end
    end
`endif

endmodule

// File: tb/tb_descrambler.sv
// Directed bench for the descrambler: a small TX scrambler produces each frame,
// outputs are collected on the falling edge and compared frame by frame.
module tb_descrambler;

    logic        clock = 1'b0;
    logic        resetN;
    logic        start;
    logic [15:0] numBits;
    logic        busy;
    logic        frameDone;
    logic [6:0]  seedOut;
`ifdef DESCRAMBLER_SERVICE_CHECK_EN
    logic        serviceError;
    logic        svcAtDone;
    logic        svcAfterStart;
`endif

    int   checks = 0;
    int   errors = 0;
    logic plainBits [0:255];
    logic txBits    [0:255];
    logic rxBits    [$];
    int   doneCount = 0;
    int   doneAtLen = 0;
    logic busyAtDone;
    logic acceptedPrev = 1'b0;
    bit   inFrame = 1'b0;
    bit   mirrorOn = 1'b0;

    always #5 clock = ~clock;

    descrambler_if streamIf ();

    descrambler #(.COUNT_WIDTH(16)) dut (
        .clock                    (clock),
        .Descrambler_Reset        (resetN),
        .Descrambler_Start        (start),
        .Descrambler_NumBits      (numBits),
        .stream                   (streamIf),
        .Descrambler_Busy         (busy),
        .Descrambler_FrameDone    (frameDone),
        .Descrambler_SeedOUT      (seedOut)
`ifdef DESCRAMBLER_SERVICE_CHECK_EN
        ,
        .Descrambler_ServiceError (serviceError)
`endif
    );

    task automatic checkVal(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    always @(posedge clock) acceptedPrev <= inFrame && streamIf.Descrambler_DataIN_VALID;

    always @(negedge clock) begin
        if (streamIf.Descrambler_DataOUTVALID) rxBits.push_back(streamIf.Descrambler_DataOUT);
        if (frameDone) begin
            doneCount++;
            doneAtLen  = rxBits.size();
            busyAtDone = busy;
`ifdef DESCRAMBLER_SERVICE_CHECK_EN
            svcAtDone  = serviceError;
`endif
        end
        if (mirrorOn) checkVal("outvalid_mirror", 32'(streamIf.Descrambler_DataOUTVALID), 32'(acceptedPrev));
    end

    // TX scrambler: plaintext ^ LFSR sequence; SERVICE bits 0..15 zero unless serviceOneAt hits one
    task automatic buildFrame(input logic [6:0] init, input int n, input bit randomPayload, input int serviceOneAt);
        logic [6:0] s;
        logic       f;
        logic       p;
        s = init;
        for (int i = 0; i < n; i++) begin
            p = (randomPayload && i >= 16) ? 1'($urandom_range(0, 1)) : 1'b0;
            if (i == serviceOneAt) p = 1'b1;
            f = s[6] ^ s[3];
            s = {s[5:0], f};
            plainBits[i] = p;
            txBits[i]    = p ^ f;
        end
    endtask

    task automatic runFrame(input int n, input int gapPct, input int abortAt, input int busyStartAt);
        int gaps;
        @(posedge clock); #1;
        start   = 1'b1;
        numBits = 16'(n);
        @(posedge clock); #1;
        start   = 1'b0;
        checkVal("busy_after_start", 32'(busy), 32'd1);
`ifdef DESCRAMBLER_SERVICE_CHECK_EN
        svcAfterStart = serviceError;
`endif
        inFrame = 1'b1;
        for (int i = 0; i < n; i++) begin
            if (i == abortAt) begin
                streamIf.Descrambler_DataIN_VALID = 1'b0;
                inFrame = 1'b0;
                resetN  = 1'b0;
                @(posedge clock); #1;
                resetN  = 1'b1;
                return;
            end
            gaps = 0;
            while (gaps < 4 && $urandom_range(0, 99) < gapPct) begin
                streamIf.Descrambler_DataIN_VALID = 1'b0;
                gaps++;
                @(posedge clock); #1;
            end
            streamIf.Descrambler_DataIN_VALID = 1'b1;
            streamIf.Descrambler_DataIN       = txBits[i];
            if (i == busyStartAt) begin
                start   = 1'b1;
                numBits = 16'd3;
            end
            @(posedge clock); #1;
            start = 1'b0;
        end
        streamIf.Descrambler_DataIN_VALID = 1'b0;
        inFrame = 1'b0;
        repeat (3) @(posedge clock);
        #1;
    endtask

    task automatic checkFrame(input string name, input int n, input int doneBefore, input logic [6:0] expSeed);
        int bad;
        bad = 0;
        for (int i = 0; i < rxBits.size() && i < n; i++)
            if (rxBits[i] !== plainBits[i]) bad++;
        checkVal({name, "_count"}, 32'(rxBits.size()), 32'(n));
        checkVal({name, "_bits"}, 32'(bad), 32'd0);
        checkVal({name, "_done"}, 32'(doneCount - doneBefore), 32'd1);
        checkVal({name, "_done_at"}, 32'(doneAtLen), 32'(n));
        checkVal({name, "_busy_at_done"}, 32'(busyAtDone), 32'd0);
        checkVal({name, "_seed"}, 32'(seedOut), 32'(expSeed));
        $display("frame %s: %0d bits, %0d mismatched, seed %b", name, rxBits.size(), bad, seedOut);
    endtask

    initial begin
        int doneBefore;
        resetN  = 1'b0;
        start   = 1'b0;
        numBits = '0;
        streamIf.Descrambler_DataIN       = 1'b0;
        streamIf.Descrambler_DataIN_VALID = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        checkVal("rst_outvalid", 32'(streamIf.Descrambler_DataOUTVALID), 32'd0);
        checkVal("rst_dataout", 32'(streamIf.Descrambler_DataOUT), 32'd0);
        checkVal("rst_busy", 32'(busy), 32'd0);
        checkVal("rst_framedone", 32'(frameDone), 32'd0);
        checkVal("rst_seed", 32'(seedOut), 32'd0);
        resetN = 1'b1;
        @(posedge clock); #1;

        // 1: all-ones scrambler, zero plaintext -> zero output, seed = first 7 sequence bits 0000111
        buildFrame(7'h7F, 127, 1'b0, -1);
        rxBits.delete();
        doneBefore = doneCount;
        runFrame(127, 0, -1, -1);
        checkFrame("t1_allones", 127, doneBefore, 7'b0000111);

        // 2: loopback from InitialState 1011101 with random payload
        buildFrame(7'b1011101, 116, 1'b1, -1);
        rxBits.delete();
        doneBefore = doneCount;
        runFrame(116, 0, -1, -1);
        checkFrame("t2_loopback", 116, doneBefore, 7'b0110110);

        // 3: same stream with ~30% input gaps and a stray Start mid-frame
        rxBits.delete();
        doneBefore = doneCount;
        mirrorOn = 1'b1;
        runFrame(116, 30, -1, 50);
        mirrorOn = 1'b0;
        checkFrame("t3_gaps", 116, doneBefore, 7'b0110110);

        // 4: reset pulse at bit 50 aborts the frame
        rxBits.delete();
        doneBefore = doneCount;
        runFrame(116, 0, 50, -1);
        @(negedge clock);
        checkVal("t4_outvalid", 32'(streamIf.Descrambler_DataOUTVALID), 32'd0);
        checkVal("t4_dataout", 32'(streamIf.Descrambler_DataOUT), 32'd0);
        checkVal("t4_busy", 32'(busy), 32'd0);
        checkVal("t4_seed", 32'(seedOut), 32'd0);
        repeat (3) @(posedge clock);
        #1;
        checkVal("t4_no_done", 32'(doneCount - doneBefore), 32'd0);
        $display("frame t4_abort: reset at bit 50, %0d outputs before abort", rxBits.size());
        rxBits.delete();
        doneBefore = doneCount;
        runFrame(116, 0, -1, -1);
        checkFrame("t4_fresh", 116, doneBefore, 7'b0110110);

        // 5: NumBits=0 ignored, valid in IDLE dropped, 5-bit frame ends in SEED with Start on last bit
        rxBits.delete();
        doneBefore = doneCount;
        @(posedge clock); #1;
        start = 1'b1;
        numBits = 16'd0;
        @(posedge clock); #1;
        start = 1'b0;
        checkVal("t5_zero_len_busy", 32'(busy), 32'd0);
        streamIf.Descrambler_DataIN       = 1'b1;
        streamIf.Descrambler_DataIN_VALID = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        streamIf.Descrambler_DataIN_VALID = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        checkVal("t5_idle_dropped", 32'(rxBits.size()), 32'd0);
        checkVal("t5_zero_len_done", 32'(doneCount - doneBefore), 32'd0);
        $display("frame t5_ignored: NumBits=0 start and idle-valid bits produced %0d outputs", rxBits.size());
        buildFrame(7'h7F, 5, 1'b0, -1);
        runFrame(5, 0, -1, 4);
        checkFrame("t5_short", 5, doneBefore, 7'b0110110);
        checkVal("t5_late_start_busy", 32'(busy), 32'd0);

`ifdef DESCRAMBLER_SERVICE_CHECK_EN
        // 6: reserved SERVICE bit 10 set, then clean frame, then a short frame
        buildFrame(7'b1011101, 40, 1'b1, 10);
        rxBits.delete();
        doneBefore = doneCount;
        runFrame(40, 0, -1, -1);
        checkFrame("t6_svc_err", 40, doneBefore, 7'b0110110);
        checkVal("t6_svc_err_flag", 32'(svcAtDone), 32'd1);
        checkVal("t6_svc_held", 32'(serviceError), 32'd1);
        buildFrame(7'b1011101, 40, 1'b1, -1);
        rxBits.delete();
        doneBefore = doneCount;
        runFrame(40, 0, -1, -1);
        checkFrame("t6_svc_ok", 40, doneBefore, 7'b0110110);
        checkVal("t6_svc_cleared_on_start", 32'(svcAfterStart), 32'd0);
        checkVal("t6_svc_ok_flag", 32'(svcAtDone), 32'd0);
        buildFrame(7'b1011101, 12, 1'b0, 10);
        rxBits.delete();
        doneBefore = doneCount;
        runFrame(12, 0, -1, -1);
        checkFrame("t6_svc_short", 12, doneBefore, 7'b0110110);
        checkVal("t6_svc_short_flag", 32'(svcAtDone), 32'd1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
